ws_systolic_array: RTL and testbench
====================================

# ws_systolic_array

Parametrised weight-stationary systolic array with double-buffered weights, internal input skew and output deskew, and a swap handshake. It sits between the activation streamer and the accumulator/writeback stage of the TPU datapath. It computes one ROWS-long activation vector times a ROWS×COLS weight tile per accepted beat. The next tile can be loaded into the shadow bank while the current one computes.

## Interface
- ROWS, 8, PE rows (reduction depth K); ≥2
- COLS, 8, PE columns (output channels N); ≥2
- DATA_WIDTH, 8, signed activation/weight width
- PSUM_WIDTH, 2*DATA_WIDTH+$clog2(ROWS), signed output width
- clk  in  1  clock
- nrst  in  1  reset: one clock; reset is synchronous and active-low
- weight_iv  in  1  weight row beat valid
- weight_id  in  COLS*DATA_WIDTH  one weight row; element c feeds column c
- weight_ready  out  1  shadow bank can accept a row
- weight_swap  in  1  request to promote shadow bank to active bank
- swap_pending  out  1  swap accepted but not yet performed
- data_iv  in  1  activation vector valid
- data_id  in  ROWS*DATA_WIDTH  unskewed activation vector; element r feeds row r
- data_ready  out  1  vector accepted when data_iv && data_ready
- data_ov  out  1  result vector valid (single-cycle pulse per vector)
- data_od  out  COLS*PSUM_WIDTH  aligned result; element c = Σ_r a[r]*W[r][c]
- busy  out  1  in-flight count nonzero

## Operation
- Weight load: each weight_iv && weight_ready writes weight_id into shadow row wrow, then wrow++. When wrow reaches ROWS-1 and that row is written, wrow wraps to 0 and shadow_full=1. weight_ready = !shadow_full.
- Swap: weight_swap with shadow_full=1 sets swap_pending. weight_swap with shadow_full=0 or swap_pending=1 is ignored. The swap executes on the first cycle with swap_pending && inflight==0. That cycle copies shadow to active and sets active_valid=1. It clears shadow_full and swap_pending.
- data_ready = active_valid && !swap_pending. Vectors accepted before the swap request drain with the old weights. No vector is accepted until the swap completes.
- Datapath:
  - Row r input is delayed r cycles (skew).
  - Activations move right one PE per cycle. Psums move down one PE per cycle.
  - PE(r,c) computes psum_out = psum_in + a*W_active[r][c], all signed. Row 0 psum_in = 0.
  - Column c bottom output is delayed COLS-1-c cycles (deskew).
- A valid bit travels alongside each vector, so bubbles are allowed and ordering is preserved.
- inflight counter: +1 on accept and -1 on data_ov. Both on the same cycle leaves it unchanged. Its maximum is ROWS+COLS.
- Arithmetic: sign-extend products to PSUM_WIDTH. The sum cannot overflow at this width. No saturation or rounding.
- Weight rows may be loaded while vectors are in flight or a swap is pending. The shadow bank is never read by the datapath.

## Timing
- Vector latency: a vector accepted on edge t produces data_ov=1 on edge t+ROWS+COLS. The latency is fixed and does not depend on bubbles.
- Throughput: 1 vector/cycle.
- Swap latency: the swap occurs on the edge after inflight reaches 0. data_ready rises on the following cycle. On an idle array the sequence is weight_swap at t, swap at t+1, data_ready at t+2.
- Loading the last weight row at edge t gives shadow_full=1 and weight_ready=0 from t+1.
- Reset (nrst=0 at an edge) forces:
  - weight_ready=1, swap_pending=0, data_ready=0, data_ov=0, data_od=0, busy=0;
  - all weights, pipeline registers, wrow, inflight, shadow_full and active_valid cleared.
- Reset mid-operation discards in-flight vectors and both banks. No data_ov is emitted for them.
- weight_swap on the same edge that the last shadow row is written is ignored, because shadow_full is not yet 1.
- data_od holds its last value when data_ov=0.

## Test plan
- Identity load, ROWS=COLS=4, DATA_WIDTH=8:
  - load W=I and swap, then send a=[1,2,3,4];
  - expect data_od=[1,2,3,4] exactly 8 cycles after accept.
- Signed extremes:
  - W all -128 and a all -128 → each column = 4*16384 = 65536; PSUM_WIDTH=18 holds it.
  - W=127 with a=-128 → each column = -65024.
- Streaming: 20 back-to-back random vectors plus 5 random bubbles → results match the reference model in order, with 20 data_ov pulses.
- Double buffer:
  - load bank B while streaming with bank A, and assert weight_swap mid-stream;
  - data_ready drops, earlier vectors complete with A, swap follows drain, and later vectors use B.
- Ignored swaps:
  - weight_swap with only 2 of 4 rows loaded → no swap_pending;
  - a 5th row while shadow_full → weight_ready=0 and the row is not written.
- Reset after 3 accepted vectors → no data_ov, all outputs at reset values, and data_ready=0 until a reload and swap.

Source files
------------

// File: rtl/ws_systolic_array_if.sv
// Handshake and data bundle between the activation streamer, weight loader and
// the weight-stationary systolic array.
interface ws_systolic_array_if #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 2*DATA_WIDTH + $clog2(ROWS)
);
    logic                       weight_iv;
    logic [COLS*DATA_WIDTH-1:0] weight_id;
    logic                       weight_ready;
    logic                       weight_swap;
    logic                       swap_pending;
    logic                       data_iv;
    logic [ROWS*DATA_WIDTH-1:0] data_id;
    logic                       data_ready;
    logic                       data_ov;
    logic [COLS*PSUM_WIDTH-1:0] data_od;
    logic                       busy;

    modport master (
        output weight_iv, weight_id, weight_swap, data_iv, data_id,
        input  weight_ready, swap_pending, data_ready, data_ov, data_od, busy
    );

    modport slave (
        input  weight_iv, weight_id, weight_swap, data_iv, data_id,
        output weight_ready, swap_pending, data_ready, data_ov, data_od, busy
    );
endinterface

// File: rtl/ws_systolic_array.sv
// Weight-stationary systolic array: double-buffered weights, input skew,
// output deskew and a swap that waits for the pipeline to drain.
module ws_systolic_array #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 2*DATA_WIDTH + $clog2(ROWS)
) (
    input logic               clk,
    input logic               nrst,
    ws_systolic_array_if.slave bus
);
    localparam int DW  = DATA_WIDTH;
    localparam int PW  = PSUM_WIDTH;
    localparam int LAT = ROWS + COLS;
    localparam int IFW = $clog2(LAT + 1);
    localparam int RW  = $clog2(ROWS);

    logic [DW-1:0]  shadow_reg [ROWS][COLS];
    logic [DW-1:0]  active_reg [ROWS][COLS];
    logic [RW-1:0]  wrow_reg;
    logic           shadow_full_reg;
    logic           swap_pending_reg;
    logic           active_valid_reg;
    logic [IFW-1:0] inflight_reg;
    logic [LAT-1:0] valid_sr_reg;
    logic           data_ov_reg;
    logic [COLS*PW-1:0] data_od_reg;

    logic w_load, accept, do_swap, data_ready;

    logic [DW-1:0] row_in   [ROWS];
    logic [DW-1:0] a_out    [ROWS][COLS-1];
    logic [PW-1:0] psum_out [ROWS][COLS];
    logic [PW-1:0] col_out  [COLS];

    assign w_load     = bus.weight_iv && !shadow_full_reg;
    assign data_ready = active_valid_reg && !swap_pending_reg;
    assign accept     = bus.data_iv && data_ready;
    // Swapping only on an empty pipeline keeps every vector on one weight set.
    assign do_swap    = swap_pending_reg && (inflight_reg == '0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wrow_reg         <= '0;
            shadow_full_reg  <= 1'b0;
            swap_pending_reg <= 1'b0;
            active_valid_reg <= 1'b0;
            inflight_reg     <= '0;
            valid_sr_reg     <= '0;
        end else begin
            if (w_load) begin
                if (wrow_reg == RW'(ROWS-1)) begin
                    wrow_reg        <= '0;
                    shadow_full_reg <= 1'b1;
                end else begin
                    wrow_reg <= wrow_reg + RW'(1);
                end
            end
            if (do_swap) begin
                active_valid_reg <= 1'b1;
                shadow_full_reg  <= 1'b0;
                swap_pending_reg <= 1'b0;
            end else if (bus.weight_swap && shadow_full_reg && !swap_pending_reg) begin
                swap_pending_reg <= 1'b1;
            end
            if (accept && !data_ov_reg)
                inflight_reg <= inflight_reg + IFW'(1);
            else if (!accept && data_ov_reg)
                inflight_reg <= inflight_reg - IFW'(1);
            valid_sr_reg <= {valid_sr_reg[LAT-2:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    shadow_reg[r][c] <= '0;
                    active_reg[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    if (w_load && wrow_reg == RW'(r))
                        shadow_reg[r][c] <= bus.weight_id[c*DW +: DW];
                    if (do_swap)
                        active_reg[r][c] <= shadow_reg[r][c];
                end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            // chain_reg[0] is the capture stage; row gi sees it gi cycles later.
            logic [DW-1:0] chain_reg [gi+1];
            always_ff @(posedge clk) begin
                if (!nrst) begin
                    for (int k = 0; k <= gi; k++) chain_reg[k] <= '0;
                end else begin
                    chain_reg[0] <= accept ? bus.data_id[gi*DW +: DW] : '0;
                    for (int k = 1; k <= gi; k++) chain_reg[k] <= chain_reg[k-1];
                end
            end
            assign row_in[gi] = chain_reg[gi];

            for (gj = 0; gj < COLS; gj++) begin : g_pe
                logic [DW-1:0]   a_in;
                logic [PW-1:0]   p_in;
                logic [2*DW-1:0] a_ext, w_ext, prod;
                logic [PW-1:0]   psum_reg;

                if (gj == 0) begin : g_a_edge
                    assign a_in = row_in[gi];
                end else begin : g_a_link
                    assign a_in = a_out[gi][gj-1];
                end
                if (gi == 0) begin : g_p_edge
                    assign p_in = '0;
                end else begin : g_p_link
                    assign p_in = psum_out[gi-1][gj];
                end

                assign a_ext = {{DW{a_in[DW-1]}}, a_in};
                assign w_ext = {{DW{active_reg[gi][gj][DW-1]}}, active_reg[gi][gj]};
                assign prod  = a_ext * w_ext;

                always_ff @(posedge clk) begin
                    if (!nrst) psum_reg <= '0;
                    else       psum_reg <= p_in + {{(PW-2*DW){prod[2*DW-1]}}, prod};
                end
                assign psum_out[gi][gj] = psum_reg;

                if (gj < COLS-1) begin : g_a_reg
                    logic [DW-1:0] a_reg;
                    always_ff @(posedge clk) begin
                        if (!nrst) a_reg <= '0;
                        else       a_reg <= a_in;
                    end
                    assign a_out[gi][gj] = a_reg;
                end
            end
        end

        for (gj = 0; gj < COLS; gj++) begin : g_deskew
            localparam int D = COLS - 1 - gj;
            if (D == 0) begin : g_direct
                assign col_out[gj] = psum_out[ROWS-1][gj];
            end else begin : g_delay
                logic [PW-1:0] dly_reg [D];
                always_ff @(posedge clk) begin
                    if (!nrst) begin
                        for (int k = 0; k < D; k++) dly_reg[k] <= '0;
                    end else begin
                        dly_reg[0] <= psum_out[ROWS-1][gj];
                        for (int k = 1; k < D; k++) dly_reg[k] <= dly_reg[k-1];
                    end
                end
                assign col_out[gj] = dly_reg[D-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nrst) begin
            data_ov_reg <= 1'b0;
            data_od_reg <= '0;
        end else begin
            data_ov_reg <= valid_sr_reg[LAT-1];
            if (valid_sr_reg[LAT-1])
                for (int c = 0; c < COLS; c++) data_od_reg[c*PW +: PW] <= col_out[c];
        end
    end

    assign bus.weight_ready = !shadow_full_reg;
    assign bus.swap_pending = swap_pending_reg;
    assign bus.data_ready   = data_ready;
    assign bus.data_ov      = data_ov_reg;
    assign bus.data_od      = data_od_reg;
    assign bus.busy         = (inflight_reg != '0);
endmodule

// File: tb/tb_ws_systolic_array.sv
// Scoreboard bench for ws_systolic_array at ROWS=COLS=4, DATA_WIDTH=8:
// stimulus pushes expected results, a negedge monitor pops and compares.
module tb_ws_systolic_array;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int PW   = 2*DW + $clog2(ROWS);
    localparam int LAT  = ROWS + COLS;

    typedef struct {
        logic [COLS*PW-1:0] od;
        int                 cyc;
    } exp_t;

    logic clk;
    logic nrst;
    int   cyc;
    int   checks;
    int   errors;
    int   ov_count;
    exp_t sb_q[$];

    int wsh  [ROWS][COLS];
    int tact [ROWS][COLS];
    int wa   [ROWS][COLS];
    int av   [ROWS];

    ws_systolic_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)) bus_if ();

    ws_systolic_array #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every data_ov pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.data_ov) begin
            ov_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ov actual=%h required=none cyc=%0d", bus_if.data_od, cyc);
            end else begin
                e = sb_q.pop_front();
                if (bus_if.data_od !== e.od || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result actual=%h@%0d required=%h@%0d", bus_if.data_od, cyc, e.od, e.cyc);
                end else begin
                    $display("out cyc=%0d od=%h", cyc, bus_if.data_od);
                end
            end
        end
    end

    function automatic logic [COLS*PW-1:0] model(input int a[ROWS], input int w[ROWS][COLS]);
        logic [COLS*PW-1:0] res;
        int s;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) s += a[r] * w[r][c];
            res[c*PW +: PW] = s[PW-1:0];
        end
        return res;
    endfunction

    function automatic logic [COLS*PW-1:0] pack_out(input int e0, input int e1, input int e2, input int e3);
        logic [COLS*PW-1:0] res;
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int c = 0; c < COLS; c++) res[c*PW +: PW] = e[c][PW-1:0];
        return res;
    endfunction

    function automatic logic [ROWS*DW-1:0] pack_a(input int a[ROWS]);
        logic [ROWS*DW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = a[r][DW-1:0];
        return v;
    endfunction

    function automatic logic [COLS*DW-1:0] pack_w_row(input int r);
        logic [COLS*DW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*DW +: DW] = wsh[r][c][DW-1:0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_row(input int r, input bit with_swap);
        int n;
        bus_if.weight_iv   = 1'b1;
        bus_if.weight_id   = pack_w_row(r);
        bus_if.weight_swap = with_swap;
        n = 0;
        while (!bus_if.weight_ready && n < 100) begin tick(); n++; end
        if (!bus_if.weight_ready) begin
            checks++; errors++;
            $display("FAIL weight_ready_timeout actual=0 required=1 row=%0d", r);
        end
        tick();
        bus_if.weight_iv   = 1'b0;
        bus_if.weight_swap = 1'b0;
    endtask

    task automatic load_bank();
        for (int r = 0; r < ROWS; r++) load_row(r, 1'b0);
    endtask

    task automatic pulse_swap();
        bus_if.weight_swap = 1'b1;
        tick();
        bus_if.weight_swap = 1'b0;
    endtask

    task automatic send(input logic [COLS*PW-1:0] exp_od, input bit track);
        int n;
        bus_if.data_iv = 1'b1;
        bus_if.data_id = pack_a(av);
        n = 0;
        while (!bus_if.data_ready && n < 100) begin tick(); n++; end
        if (!bus_if.data_ready) begin
            checks++; errors++;
            $display("FAIL data_ready_timeout actual=0 required=1");
            bus_if.data_iv = 1'b0;
            return;
        end
        tick();
        if (track) sb_q.push_back('{od: exp_od, cyc: cyc + LAT});
        bus_if.data_iv = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus_if.busy) && n < 200) begin tick(); n++; end
        check("drain_queue_empty", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_weight_ready"}, 128'(bus_if.weight_ready), 128'd1);
        check({tag, "_swap_pending"}, 128'(bus_if.swap_pending), 128'd0);
        check({tag, "_data_ready"},   128'(bus_if.data_ready),   128'd0);
        check({tag, "_data_ov"},      128'(bus_if.data_ov),      128'd0);
        check({tag, "_data_od"},      128'(bus_if.data_od),      128'd0);
        check({tag, "_busy"},         128'(bus_if.busy),         128'd0);
    endtask

    initial begin
        int ov_before;
        checks = 0; errors = 0; ov_count = 0;
        nrst = 1'b0;
        bus_if.weight_iv = 1'b0; bus_if.weight_id = '0; bus_if.weight_swap = 1'b0;
        bus_if.data_iv = 1'b0;   bus_if.data_id = '0;
        repeat (2) tick();
        check_reset_outputs("reset");
        nrst = 1'b1;
        tick();

        // Identity into shadow with ignored swap attempts along the way.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wsh[r][c] = (r == c) ? 1 : 0;
        load_row(0, 1'b0);
        load_row(1, 1'b0);
        pulse_swap();
        check("swap_ignored_partial", 128'(bus_if.swap_pending), 128'd0);
        load_row(2, 1'b0);
        load_row(3, 1'b1);
        check("swap_ignored_same_edge", 128'(bus_if.swap_pending), 128'd0);
        check("weight_ready_full", 128'(bus_if.weight_ready), 128'd0);
        bus_if.weight_iv = 1'b1;
        bus_if.weight_id = {COLS{8'h55}};
        tick();
        bus_if.weight_iv = 1'b0;
        check("weight_ready_fifth_row", 128'(bus_if.weight_ready), 128'd0);
        pulse_swap();
        check("swap_pending_set", 128'(bus_if.swap_pending), 128'd1);
        check("data_ready_while_pending", 128'(bus_if.data_ready), 128'd0);
        tick();
        check("swap_done_pending", 128'(bus_if.swap_pending), 128'd0);
        check("swap_done_data_ready", 128'(bus_if.data_ready), 128'd1);
        check("swap_done_weight_ready", 128'(bus_if.weight_ready), 128'd1);
        tact = wsh;

        av = '{1, 2, 3, 4};
        send(pack_out(1, 2, 3, 4), 1'b1);
        av = '{-5, 7, -128, 127};
        send(pack_out(-5, 7, -128, 127), 1'b1);

        // Signed extremes.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wsh[r][c] = -128;
        load_bank();
        pulse_swap();
        tact = wsh;
        av = '{-128, -128, -128, -128};
        send(pack_out(65536, 65536, 65536, 65536), 1'b1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wsh[r][c] = 127;
        load_bank();
        pulse_swap();
        tact = wsh;
        send(pack_out(-65024, -65024, -65024, -65024), 1'b1);
        drain();

        // Streaming: 20 vectors with 5 bubbles against a mixed weight tile.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wsh[r][c] = ((r*4 + c) * 37 % 256) - 128;
        load_bank();
        pulse_swap();
        tact = wsh;
        ov_before = ov_count;
        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < ROWS; r++) av[r] = ((i*53 + r*29 + 7) % 256) - 128;
            send(model(av, tact), 1'b1);
            if (i == 3 || i == 7 || i == 8 || i == 12 || i == 17) tick();
        end
        drain();
        check("stream_ov_count", 128'(ov_count - ov_before), 128'd20);

        // Double buffer: load bank B while streaming on A, swap mid-stream.
        wa = tact;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wsh[r][c] = ((r + 1) * (c + 2) * 11 % 200) - 100;
        for (int i = 0; i < 8; i++) begin
            int n;
            for (int r = 0; r < ROWS; r++) av[r] = ((i*71 + r*13 + 3) % 256) - 128;
            bus_if.data_iv     = 1'b1;
            bus_if.data_id     = pack_a(av);
            bus_if.weight_iv   = (i < ROWS);
            bus_if.weight_id   = (i < ROWS) ? pack_w_row(i) : '0;
            bus_if.weight_swap = (i == 4);
            n = 0;
            while (!bus_if.data_ready && n < 100) begin tick(); n++; end
            if (!bus_if.data_ready) begin
                checks++; errors++;
                $display("FAIL dbuf_ready_timeout actual=0 required=1 vec=%0d", i);
            end
            tick();
            sb_q.push_back('{od: (i <= 4) ? model(av, wa) : model(av, wsh), cyc: cyc + LAT});
            bus_if.data_iv = 1'b0; bus_if.weight_iv = 1'b0; bus_if.weight_swap = 1'b0;
            if (i == 4) begin
                check("dbuf_data_ready_drop", 128'(bus_if.data_ready), 128'd0);
                check("dbuf_swap_pending", 128'(bus_if.swap_pending), 128'd1);
            end
        end
        tact = wsh;
        drain();

        // Reset with three vectors in flight.
        for (int i = 0; i < 3; i++) begin
            av = '{i + 1, -i, 5, 6};
            send('0, 1'b0);
        end
        ov_before = ov_count;
        nrst = 1'b0;
        tick();
        check_reset_outputs("midreset");
        nrst = 1'b1;
        repeat (20) tick();
        check("no_ov_after_reset", 128'(ov_count), 128'(ov_before));
        check("data_ready_after_reset", 128'(bus_if.data_ready), 128'd0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wsh[r][c] = (r == c) ? 1 : 0;
        load_bank();
        pulse_swap();
        tact = wsh;
        av = '{9, -9, 100, -100};
        send(pack_out(9, -9, 100, -100), 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
